// File: rtl/boot_loader_pkg.sv
// Shared types for the boot byte loader: FSM states, default sync marker, data word type.
package boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLen0,
    StLen1,
    StAdr0,
    StAdr1,
    StData,
    StCsum
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/boot_timeout_counter.sv
// Inter-byte timeout: counts idle cycles while running, clears on load, pulses expire_o.
module boot_timeout_counter #(
  parameter int unsigned ClkFrequency = 50_000_000,
  parameter int unsigned TimeoutMs    = 100
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic run_i,
  output logic expire_o
);

  localparam longint unsigned Cycles = (64'(ClkFrequency) * 64'(TimeoutMs)) / 64'd1000;
  localparam int unsigned CntW = $clog2(Cycles + 64'd1);
  localparam logic [CntW-1:0] Last = CntW'(Cycles - 64'd1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i || !run_i) begin
      cnt_q <= '0;
    end else if (cnt_q != Last) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign expire_o = run_i && !load_i && (cnt_q == Last);

endmodule

// File: rtl/boot_byte_loader.sv
// Parses a framed boot image from the UART byte stream and writes it to program memory.
// Optional trailing checksum byte enabled by defining BOOT_LOADER_CHECKSUM_EN.
module boot_byte_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned ClkFrequency = 50_000_000,
  parameter int unsigned TimeoutMs    = 100,
  parameter int unsigned AddrWidth    = 16,
  parameter logic [7:0]  SyncByte     = SYNC_BYTE
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_data_i,
  output logic [AddrWidth-1:0] mem_addr_o,
  output word_t                mem_wdata_o,
  output logic                 mem_wr_valid_o,
  input  logic                 mem_wr_ready_i,
  output logic                 cpu_reset_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

  state_t                 state_q;
  logic [15:0]            words_q;  // writes not yet accepted
  logic [AddrWidth-1:0]   addr_q;
  logic [AddrWidth-1:0]   mem_addr_q;
  word_t                  word_q;
  word_t                  mem_wdata_q;
  logic [1:0]             idx_q;
  logic                   wr_valid_q;
  logic                   cpu_reset_q;
  logic                   done_q;
  logic                   error_q;
  logic                   boot_q;
  logic                   expire;
  logic                   run;
  logic                   wr_accept;
  word_t                  word_next;

  assign wr_accept = wr_valid_q && mem_wr_ready_i;
  assign word_next = {byte_data_i, word_q[31:8]};
  // Waiting on memory ready must not eat into the inter-byte budget.
  assign run       = (state_q != StIdle) && !wr_valid_q;

  boot_timeout_counter #(
    .ClkFrequency (ClkFrequency),
    .TimeoutMs    (TimeoutMs)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .load_i   (byte_valid_i),
    .run_i    (run),
    .expire_o (expire)
  );

`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0] sum_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
    end else if (state_q == StIdle) begin
      sum_q <= '0;
    end else if (byte_valid_i && state_q != StCsum) begin
      sum_q <= sum_q + byte_data_i;
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      words_q     <= '0;
      addr_q      <= '0;
      mem_addr_q  <= '0;
      word_q      <= '0;
      mem_wdata_q <= '0;
      idx_q       <= '0;
      wr_valid_q  <= 1'b0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      boot_q      <= 1'b1;
    end else begin
      if (wr_accept) begin
        wr_valid_q <= 1'b0;
        words_q    <= words_q - 16'd1;
      end
      unique case (state_q)
        StIdle: begin
          if (boot_q) begin
            boot_q      <= 1'b0;
            cpu_reset_q <= 1'b0;
          end
          if (byte_valid_i && byte_data_i == SyncByte) begin
            state_q     <= StLen0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_reset_q <= 1'b1;
            idx_q       <= '0;
          end
        end
        StLen0: if (byte_valid_i) begin
          words_q[7:0] <= byte_data_i;
          state_q      <= StLen1;
        end
        StLen1: if (byte_valid_i) begin
          words_q[15:8] <= byte_data_i;
          state_q       <= StAdr0;
        end
        StAdr0: if (byte_valid_i) begin
          word_q[7:0] <= byte_data_i;
          state_q     <= StAdr1;
        end
        StAdr1: if (byte_valid_i) begin
          addr_q <= AddrWidth'({byte_data_i, word_q[7:0]});
          if (words_q == 16'd0) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_q     <= StCsum;
`else
            state_q     <= StIdle;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
`endif
          end else begin
            state_q <= StData;
          end
        end
        StData: begin
          // Once the last word is queued, further bytes are not part of the data.
          if (byte_valid_i && !(wr_valid_q && words_q == 16'd1)) begin
            word_q <= word_next;
            idx_q  <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              if (wr_valid_q && !mem_wr_ready_i) begin
                error_q    <= 1'b1;
                wr_valid_q <= 1'b0;
                state_q    <= StIdle;
              end else begin
                mem_wdata_q <= word_next;
                mem_addr_q  <= addr_q;
                addr_q      <= addr_q + AddrWidth'(1);
                wr_valid_q  <= 1'b1;
              end
            end
          end
          if (wr_accept && words_q == 16'd1) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
            state_q     <= StCsum;
`else
            state_q     <= StIdle;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
`endif
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        StCsum: if (byte_valid_i) begin
          state_q <= StIdle;
          if (byte_data_i == sum_q) begin
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b0;
          end else begin
            error_q <= 1'b1;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
      if (expire) begin
        error_q    <= 1'b1;
        wr_valid_q <= 1'b0;
        state_q    <= StIdle;
      end
    end
  end

  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign mem_wr_valid_o = wr_valid_q;
  assign cpu_reset_o    = cpu_reset_q;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule

// File: tb/tb_boot_byte_loader.sv
// Directed bench for boot_byte_loader with a write scoreboard; honours BOOT_LOADER_CHECKSUM_EN.
module tb_boot_byte_loader;

  typedef logic [7:0] bytes_t[$];
  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;

  int   checks = 0;
  int   errors = 0;
  int   n_writes = 0;
  wr_t  exp_q[$];

  always #5 clk = ~clk;

  boot_byte_loader #(
    .ClkFrequency (100_000),
    .TimeoutMs    (1),
    .AddrWidth    (16),
    .SyncByte     (8'hA5)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .byte_valid_i   (byte_valid),
    .byte_data_i    (byte_data),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_wr_valid_o (mem_wr_valid),
    .mem_wr_ready_i (mem_wr_ready),
    .cpu_reset_o    (cpu_reset),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every accepted write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && mem_wr_valid && mem_wr_ready) begin
      n_writes++;
      check("write_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input bytes_t b, input int gap);
    foreach (b[i]) begin
      @(posedge clk); #1;
      byte_valid = 1'b1;
      byte_data  = b[i];
      @(posedge clk); #1;
      byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  function automatic logic [7:0] csum_of(input bytes_t b);
    logic [7:0] s = 8'h00;
    for (int i = 1; i < b.size(); i++) s = s + b[i];
    return s;
  endfunction

  // Trailing checksum byte only exists in the checksum build.
  task automatic send_csum(input bytes_t full, input logic [7:0] flip);
`ifdef BOOT_LOADER_CHECKSUM_EN
    bytes_t c;
    c.push_back(csum_of(full) ^ flip);
    send(c, 2);
`endif
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    bytes_t fr;
    bytes_t hd;
    bytes_t tl;
    bit     stable;
    int     n;
    int     w0;

    rst_n        = 1'b0;
    byte_valid   = 1'b0;
    byte_data    = 8'h00;
    mem_wr_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wr_valid", 64'(mem_wr_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("boot_cpu_release", 64'(cpu_reset), 64'd0);

    // 1: two-word frame at 0x10 with memory always ready.
    fr = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00,
           8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    push_wr(16'h0010, 32'h14131211);
    push_wr(16'h0011, 32'h18171615);
    hd = '{8'hA5};
    send(hd, 0);
    @(negedge clk);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_cpu_hold", 64'(cpu_reset), 64'd1);
    tl = fr[1:$];
    send(tl, 2);
    send_csum(fr, 8'h00);
    wait_idle("t1_idle", 200);
    check("t1_done", 64'(done), 64'd1);
    check("t1_error", 64'(error), 64'd0);
    check("t1_cpu_released", 64'(cpu_reset), 64'd0);
    check("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: memory stalls 20 cycles on the first word; request must hold steady.
    mem_wr_ready = 1'b0;
    push_wr(16'h0010, 32'h14131211);
    push_wr(16'h0011, 32'h18171615);
    hd = fr[0:8];
    send(hd, 2);
    n = 0;
    while (!mem_wr_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    stable = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!(mem_wr_valid && mem_addr == 16'h0010 && mem_wdata == 32'h14131211)) stable = 1'b0;
    end
    check("t2_hold_stable", 64'(stable), 64'd1);
    check("t2_no_write_yet", 64'(exp_q.size()), 64'd2);
    @(posedge clk); #1;
    mem_wr_ready = 1'b1;
    tl = fr[9:$];
    send(tl, 2);
    send_csum(fr, 8'h00);
    wait_idle("t2_idle", 200);
    check("t2_done", 64'(done), 64'd1);
    check("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: leading junk ignored; start at 0xFFFF so the second word wraps to 0x0000.
    hd = '{8'h00, 8'hFF};
    send(hd, 1);
    @(negedge clk);
    check("t3_junk_ignored", 64'(busy), 64'd0);
    fr = '{8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFF,
           8'h01, 8'h02, 8'h03, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    push_wr(16'hFFFF, 32'h04030201);
    push_wr(16'h0000, 32'hDDCCBBAA);
    send(fr, 2);
    send_csum(fr, 8'h00);
    wait_idle("t3_idle", 200);
    check("t3_done", 64'(done), 64'd1);
    check("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: stream goes silent mid-word; timeout aborts with no write.
    w0 = n_writes;
    fr = '{8'hA5, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03};
    send(fr, 2);
    wait_idle("t4_timeout_idle", 400);
    check("t4_error", 64'(error), 64'd1);
    check("t4_done", 64'(done), 64'd0);
    check("t4_cpu_hold", 64'(cpu_reset), 64'd1);
    check("t4_no_write", 64'(n_writes - w0), 64'd0);

    // 5: back-to-back words while memory is stalled -> overrun on the second word.
    mem_wr_ready = 1'b0;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h20, 8'h00,
           8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    send(fr, 0);
    @(negedge clk);
    check("t5_error", 64'(error), 64'd1);
    check("t5_wr_dropped", 64'(mem_wr_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_cpu_hold", 64'(cpu_reset), 64'd1);
    @(posedge clk); #1;
    mem_wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_no_write", 64'(exp_q.size()), 64'd0);

`ifdef BOOT_LOADER_CHECKSUM_EN
    // 6: checksum corrupted -> error, CPU stays held.
    fr = '{8'hA5, 8'h02, 8'h00, 8'h10, 8'h00,
           8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    push_wr(16'h0010, 32'h14131211);
    push_wr(16'h0011, 32'h18171615);
    send(fr, 2);
    send_csum(fr, 8'h01);
    wait_idle("t6_idle", 200);
    check("t6_error", 64'(error), 64'd1);
    check("t6_done", 64'(done), 64'd0);
    check("t6_cpu_hold", 64'(cpu_reset), 64'd1);
`endif

    // Recovery: a good frame after an error releases the CPU again.
    fr = '{8'hA5, 8'h01, 8'h00, 8'h30, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    push_wr(16'h0030, 32'hDEADBEEF);
    send(fr, 2);
    send_csum(fr, 8'h00);
    wait_idle("rec_idle", 200);
    check("rec_done", 64'(done), 64'd1);
    check("rec_error", 64'(error), 64'd0);
    check("rec_cpu_released", 64'(cpu_reset), 64'd0);
    check("final_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
